// File: rtl/vec_boundary_cell.sv
// Vectoring-mode CORDIC boundary cell for the complex QR systolic array.
// Emits the im->re and re->re direction-bit streams for each element and
// maintains the real diagonal element r of R across the rows of a matrix.
module vec_boundary_cell #(
  parameter int INOUT_WIDRH = 16,
  parameter int ITER_NUM    = 9
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_data_valid,
  input  logic [2*INOUT_WIDRH-1:0] i_data,
  input  logic                     i_first_in,
  input  logic                     i_last_in,
  output logic                     o_busy,
  output logic                     o_d_im2re_valid,
  output logic                     o_d_im2re,
  output logic                     o_d_re2re_valid,
  output logic                     o_d_re2re,
  output logic                     o_r_valid,
  output logic [INOUT_WIDRH-1:0]   o_r
);

  localparam int W  = INOUT_WIDRH;
  localparam int IW = W + 2;
  localparam int KW = $clog2(ITER_NUM + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VEC1,
    S_GAIN1,
    S_VEC2,
    S_GAIN2
  } state_e;

  state_e                state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic signed [IW-1:0]  x_q, x_d;
  logic signed [IW-1:0]  y_q, y_d;
  logic signed [IW-1:0]  r_int_q, r_int_d;
  logic                  first_q, first_d;
  logic                  last_q, last_d;
  logic [W-1:0]          r_q, r_d;
  logic                  r_valid_q, r_valid_d;

  logic                  dir;
  logic [KW-1:0]         sh;
  logic signed [IW-1:0]  x_sh, y_sh, x_it, y_it;
  logic signed [IW-1:0]  m_x, r_fin;
  logic [W-1:0]          re_in, im_in;

  // x * K with K = 2^-1 + 2^-3 - 2^-6 - 2^-9 (CORDIC gain compensation)
  function automatic logic signed [IW-1:0] mul_k(input logic signed [IW-1:0] v);
    return (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9);
  endfunction

  // Saturate the internal value to signed W bits
  function automatic logic [W-1:0] sat(input logic signed [IW-1:0] v);
    logic [2:0] top;
    top = v[IW-1:W-1];
    if (top == '0 || top == '1) return v[W-1:0];
    else if (v[IW-1])           return {1'b1, {(W-1){1'b0}}};
    else                        return {1'b0, {(W-1){1'b1}}};
  endfunction

  assign re_in = i_data[W-1:0];
  assign im_in = i_data[2*W-1:W];
  assign dir   = ~y_q[IW-1];
  assign sh    = k_q - 1'b1;
  assign m_x   = mul_k(x_q);
  assign r_fin = first_q ? r_int_q : m_x;

  // One CORDIC step on the working pair, steered by the current direction bit
  always_comb begin
    x_sh = x_q >>> sh;
    y_sh = y_q >>> sh;
    if (k_q == '0) begin
      x_it = dir ? y_q  : -y_q;
      y_it = dir ? -x_q : x_q;
    end else begin
      x_it = dir ? x_q + y_sh : x_q - y_sh;
      y_it = dir ? y_q - x_sh : y_q + x_sh;
    end
  end

  // Next-state and datapath update for the element sequencer
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    x_d       = x_q;
    y_d       = y_q;
    r_int_d   = r_int_q;
    first_d   = first_q;
    last_d    = last_q;
    r_d       = r_q;
    r_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_data_valid) begin
          first_d = i_first_in;
          last_d  = i_last_in;
          x_d     = {{2{re_in[W-1]}}, re_in};
          y_d     = {{2{im_in[W-1]}}, im_in};
          k_d     = '0;
          state_d = S_VEC1;
        end
      end
      S_VEC1, S_VEC2: begin
        x_d = x_it;
        y_d = y_it;
        if (k_q == KW'(ITER_NUM - 1)) begin
          k_d     = '0;
          state_d = (state_q == S_VEC1) ? S_GAIN1 : S_GAIN2;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_GAIN1: begin
        if (first_q) begin
          r_int_d = m_x;
          state_d = S_GAIN2;
        end else begin
          x_d     = r_int_q;
          y_d     = m_x;
          k_d     = '0;
          state_d = S_VEC2;
        end
      end
      S_GAIN2: begin
        r_int_d   = r_fin;
        r_d       = sat(r_fin);
        r_valid_d = last_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared by asynchronous reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      r_int_q   <= '0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      r_q       <= '0;
      r_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      x_q       <= x_d;
      y_q       <= y_d;
      r_int_q   <= r_int_d;
      first_q   <= first_d;
      last_q    <= last_d;
      r_q       <= r_d;
      r_valid_q <= r_valid_d;
    end
  end

  assign o_busy          = (state_q != S_IDLE);
  assign o_d_im2re_valid = (state_q == S_VEC1);
  assign o_d_im2re       = (state_q == S_VEC1) & dir;
  assign o_d_re2re_valid = (state_q == S_VEC2);
  assign o_d_re2re       = (state_q == S_VEC2) & dir;
  assign o_r_valid       = r_valid_q;
  assign o_r             = r_q;

endmodule

// File: tb/tb_vec_boundary_cell.sv
// Self-checking bench for vec_boundary_cell: directed table, reset and
// back-to-back sequences, then random matrices against a reference model.
module tb_vec_boundary_cell;

  localparam int W = 16;
  localparam int N = 9;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_data_valid;
  logic [2*W-1:0] i_data;
  logic         i_first_in, i_last_in;
  logic         o_busy, o_d_im2re_valid, o_d_im2re, o_d_re2re_valid, o_d_re2re;
  logic         o_r_valid;
  logic [W-1:0] o_r;

  int n_checks = 0;
  int n_fail   = 0;
  int mdl_r    = 0;

  always #5 clk = ~clk;

  vec_boundary_cell #(.INOUT_WIDRH(W), .ITER_NUM(N)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data_valid(i_data_valid), .i_data(i_data),
    .i_first_in(i_first_in), .i_last_in(i_last_in), .o_busy(o_busy),
    .o_d_im2re_valid(o_d_im2re_valid), .o_d_im2re(o_d_im2re),
    .o_d_re2re_valid(o_d_re2re_valid), .o_d_re2re(o_d_re2re),
    .o_r_valid(o_r_valid), .o_r(o_r)
  );

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    bit          first;
    bit          last;
    int          r_exp;
    int          tol;
    bit          q0;
  } vec_t;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_tol(input string name, input int got, input real exp, input real tol);
    real diff;
    n_checks++;
    diff = real'(got) - exp;
    if (diff < 0.0) diff = -diff;
    if (diff > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0.1f +/- %0.1f", name, got, exp, tol);
    end
  endtask

  // Reference vectoring CORDIC from the iteration rules, on plain integers
  function automatic int cordic(input int xi, input int yi, output logic [N-1:0] bits);
    int x, y, t;
    bit d;
    x = xi; y = yi; bits = '0;
    for (int k = 0; k < N; k++) begin
      d = (y >= 0);
      bits = {bits[N-2:0], d};
      if (k == 0) begin
        t = x;
        if (d) begin x = y;  y = -t; end
        else   begin x = -y; y = t;  end
      end else begin
        t = x;
        if (d) begin x = x + (y >>> (k-1)); y = y - (t >>> (k-1)); end
        else   begin x = x - (y >>> (k-1)); y = y + (t >>> (k-1)); end
      end
    end
    return x;
  endfunction

  function automatic int mul_k(input int v);
    return (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9);
  endfunction

  function automatic int sat16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Row model: returns the new r and updates the persistent model r
  function automatic int model_row(input int re, input int im, input bit first,
                                   output logic [N-1:0] b1, output logic [N-1:0] b2);
    int x1, x2, m, r;
    b2 = '0;
    x1 = cordic(re, im, b1);
    m  = mul_k(x1);
    if (first) r = m;
    else begin
      x2 = cordic(mdl_r, m, b2);
      r  = mul_k(x2);
    end
    mdl_r = r;
    return r;
  endfunction

  task automatic run_row(input logic [15:0] re, input logic [15:0] im, input bit first,
                         input bit last, output int r_got, output bit q0_got);
    logic [N-1:0] eb1, eb2, gb1, gb2;
    int r, ne, n, im_cnt, re_cnt, im_first, re_first, ovl;
    r  = model_row($signed(re), $signed(im), first, eb1, eb2);
    ne = first ? N + 2 : 2*N + 2;
    gb1 = '0; gb2 = '0;
    im_cnt = 0; re_cnt = 0; im_first = -1; re_first = -1; ovl = 0;
    i_data = {im, re}; i_first_in = first; i_last_in = last; i_data_valid = 1'b1;
    @(posedge clk); #1;
    i_data_valid = 1'b0;
    for (n = 0; n < 64; n++) begin
      if (!o_busy) break;
      if (o_d_im2re_valid) begin
        if (im_first < 0) im_first = n;
        im_cnt++;
        gb1 = {gb1[N-2:0], o_d_im2re};
      end
      if (o_d_re2re_valid) begin
        if (re_first < 0) re_first = n;
        re_cnt++;
        gb2 = {gb2[N-2:0], o_d_re2re};
      end
      if (o_d_im2re_valid && o_d_re2re_valid) ovl++;
      // a stray element while busy must be dropped
      if (n == 3) begin
        i_data_valid = 1'b1; i_data = $urandom; i_first_in = 1'b1; i_last_in = 1'b1;
      end else begin
        i_data_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    i_data_valid = 1'b0;
    check("end_cycle", n, ne);
    check("im2re_count", im_cnt, N);
    check("im2re_start", im_first, 0);
    check("im2re_bits", int'(gb1), int'(eb1));
    check("re2re_count", re_cnt, first ? 0 : N);
    if (!first) begin
      check("re2re_start", re_first, N + 1);
      check("re2re_bits", int'(gb2), int'(eb2));
    end
    check("stream_overlap", ovl, 0);
    check("r_valid", int'(o_r_valid), int'(last));
    check("o_r_model", $signed(o_r), sat16(r));
    r_got  = $signed(o_r);
    q0_got = gb1[N-1];
    @(posedge clk); #1;
    check("r_valid_pulse", int'(o_r_valid), 0);
  endtask

  vec_t tbl[5];

  initial begin
    int   r_got, stray;
    bit   q0;
    logic [15:0] hr_re[3];
    logic [15:0] hr_im[3];
    int   hexp[3];
    logic [N-1:0] b1, b2;
    int   acc, upd, pulses;
    bit   prev_busy;
    real  sumsq;

    tbl[0] = '{16'h0999, 16'h0CCC, 1'b1, 1'b1, 32'h1000, 8,  1'b1};
    tbl[1] = '{16'h0999, 16'h0CCC, 1'b1, 1'b0, 32'h1000, 8,  1'b1};
    tbl[2] = '{16'h0000, 16'hF000, 1'b0, 1'b1, 32'h16A1, 12, 1'b0};
    tbl[3] = '{16'h7000, 16'h7000, 1'b1, 1'b1, 32'h7FFF, 0,  1'b1};
    tbl[4] = '{16'hF000, 16'h0000, 1'b1, 1'b1, 32'h1000, 8,  1'b1};

    rst_n = 1'b0; i_data_valid = 1'b0; i_data = '0; i_first_in = 1'b0; i_last_in = 1'b0;
    #1;
    check("reset_busy", int'(o_busy), 0);
    check("reset_o_r", int'(o_r), 0);
    check("reset_r_valid", int'(o_r_valid), 0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 5; i++) begin
      run_row(tbl[i].re, tbl[i].im, tbl[i].first, tbl[i].last, r_got, q0);
      check_tol($sformatf("table%0d_r", i), r_got, real'(tbl[i].r_exp), real'(tbl[i].tol));
      check($sformatf("table%0d_q0", i), int'(q0), int'(tbl[i].q0));
    end

    // Reset in the middle of VEC1
    i_data = {16'h0CCC, 16'h0999}; i_first_in = 1'b1; i_last_in = 1'b1; i_data_valid = 1'b1;
    @(posedge clk); #1;
    i_data_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_busy", int'(o_busy), 0);
    check("rst_im2re_valid", int'(o_d_im2re_valid), 0);
    check("rst_im2re", int'(o_d_im2re), 0);
    check("rst_re2re_valid", int'(o_d_re2re_valid), 0);
    check("rst_re2re", int'(o_d_re2re), 0);
    check("rst_r_valid", int'(o_r_valid), 0);
    check("rst_o_r", int'(o_r), 0);
    stray = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (o_d_im2re_valid || o_d_re2re_valid || o_busy) stray++;
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (o_d_im2re_valid || o_d_re2re_valid || o_busy || o_r_valid) stray++;
    end
    check("rst_no_stream", stray, 0);
    mdl_r = 0;
    // a non-first row right after reset builds on the cleared r
    run_row(16'h0400, 16'h0300, 1'b0, 1'b1, r_got, q0);
    check_tol("post_reset_r", r_got, 1280.0, 8.0);
    run_row(16'h0999, 16'h0CCC, 1'b1, 1'b1, r_got, q0);
    check_tol("post_reset_r2", r_got, 4096.0, 8.0);

    // Valid held high through a 3-row matrix
    hr_re[0] = 16'h0800; hr_im[0] = 16'h0400;
    hr_re[1] = 16'hFC00; hr_im[1] = 16'h0200;
    hr_re[2] = 16'h0300; hr_im[2] = 16'hF900;
    for (int i = 0; i < 3; i++)
      hexp[i] = sat16(model_row($signed(hr_re[i]), $signed(hr_im[i]), i == 0, b1, b2));
    acc = 0; upd = 0; pulses = 0; prev_busy = 1'b0;
    i_data = {hr_im[0], hr_re[0]}; i_first_in = 1'b1; i_last_in = 1'b0; i_data_valid = 1'b1;
    for (int c = 0; c < 200 && upd < 3; c++) begin
      @(posedge clk); #1;
      if (o_busy && !prev_busy) begin
        acc++;
        if (acc < 3) begin
          i_data = {hr_im[acc], hr_re[acc]}; i_first_in = 1'b0; i_last_in = (acc == 2);
        end else begin
          i_data_valid = 1'b0;
        end
      end
      if (!o_busy && prev_busy) begin
        check($sformatf("held_r_row%0d", upd), $signed(o_r), hexp[upd]);
        upd++;
      end
      if (o_r_valid) pulses++;
      prev_busy = o_busy;
    end
    i_data_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (o_r_valid) pulses++;
      if (o_busy) acc++;
    end
    check("held_accepts", acc, 3);
    check("held_updates", upd, 3);
    check("held_pulses", pulses, 1);

    // Random matrices: exact model plus magnitude against sqrt of the column norm
    for (int t = 0; t < 8; t++) begin
      int rows, re_i, im_i;
      rows  = $urandom_range(1, 4);
      sumsq = 0.0;
      for (int r = 0; r < rows; r++) begin
        re_i = int'($urandom_range(0, 16383)) - 8192;
        im_i = int'($urandom_range(0, 16383)) - 8192;
        sumsq += real'(re_i) * real'(re_i) + real'(im_i) * real'(im_i);
        run_row(16'(re_i), 16'(im_i), r == 0, r == rows - 1, r_got, q0);
        check_tol($sformatf("rand%0d_row%0d_norm", t, r), r_got, $sqrt(sumsq),
                  $sqrt(sumsq) * 0.002 + 16.0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
